// File: rtl/pkt_framer_pkg.sv
// Shared definitions for the packet framer and the switch it feeds:
// FSM encoding, header bit layout, port count and descriptor legality check.
package pkt_framer_pkg;

    localparam int NPORTS = 3;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int PORT_MSB = 1;
    localparam int PORT_LSB = 0;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_PAY  = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

    // maxlen counts the header byte, so the payload must stay strictly below it.
    function automatic logic hdr_legal(input logic [1:0] port,
                                       input logic [5:0] len,
                                       input int         maxlen);
        return (32'(port) < NPORTS) && (len != 6'd0) && (int'(len) < maxlen);
    endfunction

endpackage

// File: rtl/pkt_framer.sv
// Prepends {len,port} to a payload stream; header 1 cycle after descriptor, each byte 1 cycle after its handshake.
// Admits a packet only while f_ready is high in IDLE; payload accepted whenever in PAY, f_ready ignored there.
module pkt_framer
    import pkt_framer_pkg::*;
#(
    parameter int MAXLENGTH = 12,
    parameter int GAP       = 2,
    parameter int CNTW      = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    input  logic [1:0]      cmd_port,
    input  logic [5:0]      cmd_len,
    output logic            cmd_ready,
    input  logic            s_valid,
    input  logic [7:0]      s_data,
    output logic            s_ready,
    output logic            f_valid,
    output logic [7:0]      f_data,
    output logic            f_end,
    input  logic            f_ready,
    output logic            err,
    output logic            busy,
    output logic [CNTW-1:0] pkt_cnt,
    output logic [CNTW-1:0] err_cnt
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    state_t            r_state;
    logic [5:0]        r_len;
    logic [1:0]        r_port;
    logic [5:0]        r_cnt;
    logic [GW-1:0]     r_gap_cnt;
    logic              r_f_valid;
    logic [7:0]        r_f_data;
    logic              r_f_end;
    logic              r_err;
    logic              r_busy;
    logic [CNTW-1:0]   r_pkt_cnt;
    logic [CNTW-1:0]   r_err_cnt;

    state_t            w_state_nxt;
    logic              w_cmd_hs;
    logic              w_s_hs;
    logic              w_legal;
    logic              w_last;
    logic              w_gap_done;

    assign cmd_ready = (r_state == ST_IDLE) && f_ready;
    assign s_ready   = (r_state == ST_PAY);

    assign w_cmd_hs  = cmd_valid && cmd_ready;
    assign w_s_hs    = s_valid && s_ready;
    assign w_legal   = hdr_legal(cmd_port, cmd_len, MAXLENGTH);
    assign w_last    = (r_cnt == (r_len - 6'd1));

    // The f_end cycle is not an idle cycle; the GAP idle cycles are counted after it.
    assign w_gap_done = !r_f_end && (r_gap_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_cmd_hs && w_legal)  w_state_nxt = ST_PAY;
            ST_PAY:  if (w_s_hs && w_last)     w_state_nxt = ST_GAP;
            ST_GAP:  if (w_gap_done)           w_state_nxt = ST_IDLE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_port    <= '0;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
            r_f_valid <= 1'b0;
            r_f_data  <= '0;
            r_f_end   <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_f_valid <= 1'b0;
            r_f_data  <= '0;
            r_f_end   <= 1'b0;
            r_err     <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_hs) begin
                        if (w_legal) begin
                            r_len                        <= cmd_len;
                            r_port                       <= cmd_port;
                            r_cnt                        <= '0;
                            r_f_valid                    <= 1'b1;
                            r_f_data[LEN_MSB:LEN_LSB]    <= cmd_len;
                            r_f_data[PORT_MSB:PORT_LSB]  <= cmd_port;
                        end else begin
                            r_err     <= 1'b1;
                            r_err_cnt <= r_err_cnt + CNTW'(1);
                        end
                    end
                end
                ST_PAY: begin
                    if (w_s_hs) begin
                        r_f_valid <= 1'b1;
                        r_f_data  <= s_data;
                        r_cnt     <= r_cnt + 6'd1;
                        if (w_last) begin
                            r_f_end   <= 1'b1;
                            r_pkt_cnt <= r_pkt_cnt + CNTW'(1);
                            r_gap_cnt <= GW'(GAP - 1);
                        end
                    end
                end
                ST_GAP: begin
                    if (!r_f_end && (r_gap_cnt != '0))
                        r_gap_cnt <= r_gap_cnt - GW'(1);
                end
                default: ;
            endcase
        end
    end

    // A packet in flight must always carry a port the switch can route.
    a_port_routable: assert property (@(posedge clk) disable iff (!reset)
        (r_state != ST_IDLE) |-> (32'(r_port) < NPORTS));

    assign f_valid = r_f_valid;
    assign f_data  = r_f_data;
    assign f_end   = r_f_end;
    assign err     = r_err;
    assign busy    = r_busy;
    assign pkt_cnt = r_pkt_cnt;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_pkt_framer.sv
// Directed and randomized checks of pkt_framer against a queue-based packet model.
module tb_pkt_framer;

    localparam int MAXLENGTH = 12;
    localparam int GAP       = 2;
    localparam int CNTW      = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic [1:0]      cmd_port;
    logic [5:0]      cmd_len;
    logic            cmd_ready;
    logic            s_valid;
    logic [7:0]      s_data;
    logic            s_ready;
    logic            f_valid;
    logic [7:0]      f_data;
    logic            f_end;
    logic            f_ready;
    logic            err;
    logic            busy;
    logic [CNTW-1:0] pkt_cnt;
    logic [CNTW-1:0] err_cnt;

    pkt_framer #(.MAXLENGTH(MAXLENGTH), .GAP(GAP), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_port(cmd_port), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .f_valid(f_valid), .f_data(f_data), .f_end(f_end), .f_ready(f_ready),
        .err(err), .busy(busy), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       e;
        logic [7:0] d;
    } cap_t;

    cap_t cap_q[$];
    int   err_seen = 0;
    int   bad_idle = 0;

    always @(negedge clk) begin
        if (f_valid) cap_q.push_back('{cyc, f_end, f_data});
        else if (f_data !== 8'd0 || f_end !== 1'b0) bad_idle++;
        if (err) err_seen++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue_cmd(input logic [1:0] p, input logic [5:0] l, output int hs);
        cmd_valid = 1'b1;
        cmd_port  = p;
        cmd_len   = l;
        hs        = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                hs = cyc;
                break;
            end
        end
        chk("cmd_handshake_wait", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] d[64], input int gaps[64], input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b0;
            repeat (gaps[i]) begin
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = d[i];
            for (int j = 0; j < 20; j++) begin
                @(negedge clk);
                if (s_ready) break;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_data  = 8'd0;
    endtask

    // Expected stream: header = len*4 + port, then the payload with end on the last byte.
    task automatic check_pkt(input string tag, input logic [1:0] p, input logic [5:0] l,
                             input logic [7:0] d[64]);
        int h;
        int ev;
        h = int'(l) * 4 + int'(p);
        chk({tag, "_nbytes"}, 32'(cap_q.size()), 32'(int'(l) + 1));
        if (cap_q.size() == int'(l) + 1) begin
            chk({tag, "_hdr"}, {23'd0, cap_q[0].e, cap_q[0].d}, 32'(h));
            for (int i = 0; i < int'(l); i++) begin
                ev = ((i == int'(l) - 1) ? 256 : 0) + int'(d[i]);
                chk({tag, "_byte"}, {23'd0, cap_q[i+1].e, cap_q[i+1].d}, 32'(ev));
            end
        end
        cap_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [7:0] d[64];
        int         g[64];
        int         hs, rise, rdy_cyc, end_cyc, stuck, nleg, nill, kind;
        logic [1:0] p;
        logic [5:0] l;
        logic [1:0] ill_port[3];
        logic [5:0] ill_len[3];

        reset = 1'b0; cmd_valid = 1'b0; cmd_port = 2'd0; cmd_len = 6'd0;
        s_valid = 1'b0; s_data = 8'd0; f_ready = 1'b1;
        foreach (g[i]) g[i] = 0;
        foreach (d[i]) d[i] = 8'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_f_valid", 32'(f_valid), 32'd0);
        chk("rst_f_data",  32'(f_data),  32'd0);
        chk("rst_f_end",   32'(f_end),   32'd0);
        chk("rst_err",     32'(err),     32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_cmd_rdy", 32'(cmd_ready), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;

        // Legal packet, contiguous payload
        d[0] = 8'hA1; d[1] = 8'hA2; d[2] = 8'hA3;
        issue_cmd(2'd1, 6'd3, hs);
        send_bytes(d, g, 3);
        repeat (2) @(negedge clk);
        chk("t1_hdr_latency", 32'(cap_q[0].cyc - hs), 32'd1);
        chk("t1_contiguous",  32'(cap_q[3].cyc - cap_q[0].cyc), 32'd3);
        chk("t1_busy_in_gap", 32'(busy), 32'd1);
        check_pkt("t1", 2'd1, 6'd3, d);
        chk("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);

        // Length-1 packet and the inter-packet gap
        d[0] = 8'h55;
        issue_cmd(2'd2, 6'd1, hs);
        send_bytes(d, g, 1);
        rdy_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                rdy_cyc = cyc;
                break;
            end
        end
        end_cyc = cap_q[cap_q.size()-1].cyc;
        chk("t2_end_to_ready", 32'(rdy_cyc - end_cyc), 32'(GAP + 1));
        check_pkt("t2", 2'd2, 6'd1, d);
        chk("t2_pkt_cnt", 32'(pkt_cnt), 32'd2);
        @(posedge clk); #1;

        // Illegal descriptors back to back, payload offered but must be ignored
        ill_port[0] = 2'd3; ill_len[0] = 6'd4;
        ill_port[1] = 2'd0; ill_len[1] = 6'd0;
        ill_port[2] = 2'd0; ill_len[2] = 6'd12;
        err_seen = 0;
        s_valid = 1'b1; s_data = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            cmd_valid = 1'b1; cmd_port = ill_port[k]; cmd_len = ill_len[k];
            @(negedge clk);
            chk("t3_cmd_ready", 32'(cmd_ready), 32'd1);
            chk("t3_s_ready",   32'(s_ready),   32'd0);
            if (k > 0) chk("t3_err_pulse", 32'(err), 32'd1);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("t3_err_last", 32'(err), 32'd1);
        @(negedge clk);
        chk("t3_err_drop", 32'(err), 32'd0);
        chk("t3_err_seen", 32'(err_seen), 32'd3);
        chk("t3_err_cnt",  32'(err_cnt),  32'd3);
        chk("t3_no_output", 32'(cap_q.size()), 32'd0);
        chk("t3_idle", 32'(busy), 32'd0);
        s_valid = 1'b0; s_data = 8'd0;
        @(posedge clk); #1;

        // Back-pressure in IDLE, then a payload gap
        f_ready = 1'b0;
        cmd_valid = 1'b1; cmd_port = 2'd0; cmd_len = 6'd2;
        stuck = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0 || busy !== 1'b0) stuck++;
        end
        chk("t4_held", 32'(stuck), 32'd0);
        @(posedge clk); #1;
        f_ready = 1'b1;
        rise = cyc;
        issue_cmd(2'd0, 6'd2, hs);
        f_ready = 1'b0;
        d[0] = 8'h11; d[1] = 8'h22; g[0] = 0; g[1] = 1;
        send_bytes(d, g, 2);
        g[1] = 0;
        repeat (2) @(negedge clk);
        chk("t4_rise_to_hs", 32'(hs - rise), 32'd0);
        chk("t4_hdr_latency", 32'(cap_q[0].cyc - rise), 32'd1);
        chk("t4_b0_cycle", 32'(cap_q[1].cyc - cap_q[0].cyc), 32'd1);
        chk("t4_b1_cycle", 32'(cap_q[2].cyc - cap_q[0].cyc), 32'd3);
        check_pkt("t4", 2'd0, 6'd2, d);
        f_ready = 1'b1;

        // Reset mid-packet, while a payload byte is on the output
        d[0] = 8'h91;
        issue_cmd(2'd1, 6'd5, hs);
        send_bytes(d, g, 1);
        chk("t5_pre_valid", 32'(f_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("t5_rst_f_valid", 32'(f_valid), 32'd0);
        chk("t5_rst_f_data",  32'(f_data),  32'd0);
        chk("t5_rst_busy",    32'(busy),    32'd0);
        chk("t5_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("t5_rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("t5_rst_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        cap_q.delete();
        reset = 1'b1;
        @(posedge clk); #1;
        d[0] = 8'h3C; d[1] = 8'hC3;
        issue_cmd(2'd0, 6'd2, hs);
        send_bytes(d, g, 2);
        repeat (2) @(negedge clk);
        check_pkt("t5", 2'd0, 6'd2, d);
        chk("t5_pkt_cnt", 32'(pkt_cnt), 32'd1);

        // Randomized packets, with illegal descriptors mixed in
        nleg = 0; nill = 0;
        while (nleg < 20) begin
            @(posedge clk); #1;
            f_ready = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            f_ready = 1'b1;
            if ($urandom_range(0, 4) == 0) begin
                kind = $urandom_range(0, 2);
                p = (kind == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                l = (kind == 1) ? 6'd0 :
                    (kind == 2) ? 6'($urandom_range(MAXLENGTH, 63)) :
                                  6'($urandom_range(1, MAXLENGTH - 1));
                issue_cmd(p, l, hs);
                chk("rnd_err_pulse", 32'(err), 32'd1);
                nill++;
            end else begin
                p = 2'($urandom_range(0, 2));
                l = (nleg == 0) ? 6'(MAXLENGTH - 1) : 6'($urandom_range(1, MAXLENGTH - 1));
                for (int i = 0; i < int'(l); i++) begin
                    d[i] = 8'($urandom_range(0, 255));
                    g[i] = $urandom_range(0, 2);
                end
                issue_cmd(p, l, hs);
                f_ready = 1'($urandom_range(0, 1));
                send_bytes(d, g, int'(l));
                repeat (2) @(negedge clk);
                check_pkt("rnd", p, l, d);
                f_ready = 1'b1;
                nleg++;
            end
        end
        chk("rnd_pkt_cnt", 32'(pkt_cnt), 32'd21);
        chk("rnd_err_cnt", 32'(err_cnt), 32'(nill));
        chk("idle_data_zero", 32'(bad_idle), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
